// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 keyboard frame receiver with glitch filter, parity/stop check and inter-edge timeout.
// Define PS2_BREAK_DECODE_EN to fold an F0 break prefix into RELEASE on the following code.
module ps2_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic [7:0] SCANCODE,
   output logic       VALID,
   output logic       RELEASE,
   output logic       ERROR
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state, state_n;
   logic clk_s1, clk_s2, dat_s1, dat_s2, flt_lvl, flip, fall, accept, fail, par;
   logic [7:0] flt_cnt, shreg;
   logic [2:0] bit_cnt;
   logic [TW-1:0] tmo_cnt;
   assign flip = (clk_s2 != flt_lvl) && (flt_cnt == 8'(FILTER_LEN - 1));
   assign fall = flip && flt_lvl;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         {clk_s1, clk_s2, dat_s1, dat_s2, flt_lvl} <= '1;
         flt_cnt <= '0;
      end else begin
         {clk_s2, clk_s1} <= {clk_s1, PS2_CLK};
         {dat_s2, dat_s1} <= {dat_s1, PS2_DATA};
         flt_cnt <= (clk_s2 == flt_lvl || flip) ? '0 : flt_cnt + 8'd1;
         flt_lvl <= flt_lvl ^ flip;
      end
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      fail    = 1'b0;
      if (fall) begin
         case (state)
            IDLE:    state_n = dat_s2 ? IDLE : DATA;
            DATA:    state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
            PARITY:  state_n = STOP;
            default: begin
               state_n = IDLE;
               accept  = dat_s2 && (^{shreg, par});
               fail    = !accept;
            end
         endcase
      end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
         state_n = IDLE;
         fail    = 1'b1;
      end
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tmo_cnt <= '0;
         shreg   <= '0;
         bit_cnt <= '0;
         par     <= 1'b0;
         ERROR   <= 1'b0;
      end else begin
         tmo_cnt <= (fall || state == IDLE) ? '0 : tmo_cnt + TW'(1);
         if (state == IDLE) bit_cnt <= '0;
         if (fall && state == DATA) begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (fall && state == PARITY) par <= dat_s2;
         ERROR <= fail;
      end
   end
`ifdef PS2_BREAK_DECODE_EN
   logic pend, is_brk;
   assign is_brk = shreg == 8'hF0;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pend     <= 1'b0;
         VALID    <= 1'b0;
         RELEASE  <= 1'b0;
         SCANCODE <= '0;
      end else begin
         VALID <= accept && !is_brk;
         pend  <= (accept && is_brk) || (pend && !accept && !fail);
         if (accept && !is_brk) begin
            SCANCODE <= shreg;
            RELEASE  <= pend;
         end
      end
   end
`else
   assign RELEASE = 1'b0;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         VALID    <= 1'b0;
         SCANCODE <= '0;
      end else begin
         VALID <= accept;
         if (accept) SCANCODE <= shreg;
      end
   end
`endif
endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: randomized PS/2 frames against a queue-based reference model of expected VALID/ERROR events.
module tb_ps2_receiver;
   localparam int FLT = 8, TMO = 400, HALF = 40;
   logic CLK = 0, RST_N = 0, PS2_CLK = 1, PS2_DATA = 1;
   logic [7:0] SCANCODE;
   logic VALID, RELEASE, ERROR;
   int n_chk = 0, n_fail = 0;
   typedef struct {bit err; logic [7:0] code; bit rel;} ev_t;
   ev_t exp_q[$];
   logic [7:0] m_sc = 0;
   bit m_rel = 0, m_pend = 0;

   ps2_receiver #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
      .SCANCODE(SCANCODE), .VALID(VALID), .RELEASE(RELEASE), .ERROR(ERROR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_good(input logic [7:0] b);
`ifdef PS2_BREAK_DECODE_EN
      if (b == 8'hF0) m_pend = 1;
      else begin
         m_sc = b; m_rel = m_pend; m_pend = 0;
         exp_q.push_back('{0, b, m_rel});
      end
`else
      m_sc = b;
      exp_q.push_back('{0, b, 0});
`endif
   endtask

   task automatic expect_err();
      m_pend = 0;
      exp_q.push_back('{1, m_sc, m_rel});
   endtask

   task automatic send(input logic [10:0] bits, input int n, input bit glitch);
      for (int i = 0; i < n; i++) begin
         PS2_DATA = bits[i];
         if (glitch) begin
            repeat (10) @(negedge CLK);
            PS2_CLK = 0;
            repeat (3) @(negedge CLK);
            PS2_CLK = 1;
            repeat (HALF - 13) @(negedge CLK);
         end else repeat (HALF) @(negedge CLK);
         PS2_CLK = 0;
         repeat (HALF) @(negedge CLK);
         PS2_CLK = 1;
      end
      PS2_DATA = 1;
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b, input int fault);
      return {fault != 2, (~^b) ^ (fault == 1), b, 1'b0};
   endfunction

   // fault: 0 good, 1 bad parity, 2 bad stop
   task automatic frame(input logic [7:0] b, input int fault, input bit glitch);
      if (fault == 0) expect_good(b);
      else expect_err();
      send(mk(b, fault), 11, glitch);
      repeat (150) @(negedge CLK);
   endtask

   always @(negedge CLK) begin : mon
      ev_t e;
      if (RST_N && (VALID || ERROR)) begin
         chk("excl", {31'b0, VALID & ERROR}, 0);
         if (exp_q.size() == 0) chk("spurious", {30'b0, VALID, ERROR}, 0);
         else begin
            e = exp_q.pop_front();
            chk("kind", {31'b0, ERROR}, {31'b0, e.err});
            chk("code", {24'b0, SCANCODE}, {24'b0, e.code});
            chk("rel", {31'b0, RELEASE}, {31'b0, e.rel});
         end
      end
   end

   initial begin
      repeat (5) @(negedge CLK);
      chk("rst_sc", {24'b0, SCANCODE}, 0);
      chk("rst_valid", {31'b0, VALID}, 0);
      chk("rst_rel", {31'b0, RELEASE}, 0);
      chk("rst_err", {31'b0, ERROR}, 0);
      RST_N = 1;
      repeat (20) @(negedge CLK);
      frame(8'h1C, 0, 0);
      chk("sc_1c", {24'b0, SCANCODE}, 32'h1C);
      frame(8'h1C, 1, 0);
      chk("sc_hold", {24'b0, SCANCODE}, 32'h1C);
      expect_err();
      send(mk(8'h32, 0), 5, 0);
      repeat (TMO + 200) @(negedge CLK);
      frame(8'h32, 0, 0);
      chk("sc_32", {24'b0, SCANCODE}, 32'h32);
      frame(8'h5A, 0, 1);
      chk("sc_5a", {24'b0, SCANCODE}, 32'h5A);
      frame(8'hF0, 0, 0);
      frame(8'h1C, 0, 0);
      chk("sc_brk", {24'b0, SCANCODE}, 32'h1C);
      send(mk(8'h55, 0), 6, 0);
      repeat (10) @(negedge CLK);
      RST_N = 0;
      repeat (3) @(negedge CLK);
      chk("mid_rst_sc", {24'b0, SCANCODE}, 0);
      chk("mid_rst_q", exp_q.size(), 0);
      m_sc = 0; m_rel = 0; m_pend = 0;
      RST_N = 1;
      repeat (20) @(negedge CLK);
      frame(8'h29, 0, 0);
      chk("sc_29", {24'b0, SCANCODE}, 32'h29);
      for (int k = 0; k < 30; k++) begin
         int f;
         logic [7:0] b;
         f = $urandom_range(0, 5);
         b = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
         frame(b, (f == 3) ? 1 : (f == 4) ? 2 : 0, f == 5);
      end
      repeat (500) @(negedge CLK);
      chk("drain", exp_q.size(), 0);
      chk("final_sc", {24'b0, SCANCODE}, {24'b0, m_sc});
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
